risc_trace_checker: RTL and testbench
=====================================

# risc_trace_checker

Parametrised, self-checking retirement monitor for the single-cycle RISC core. It holds a programmable table of expected (PC, instruction, ALU result) triples and compares it, in order, against the core's retire stream. It counts mismatches, records the first failing index and raises a watchdog timeout when the core stops retiring. It sits beside `risc` in simulation and in FPGA bring-up builds, replacing eyeball checks of monitored PC/ALU traces with a pass/fail verdict.

## Interface
- `XLEN`, 32: width of PC, instruction and result fields.
- `DEPTH`, 64: number of expected-trace entries; power of two, ≥2.
- `TIMEOUT`, 256: idle cycles in RUN without `ret_valid` before timeout; ≥1.
- `CNT_W`, 8: width of the mismatch counter.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `ret_valid` in 1: core retired an instruction this cycle.
- `ret_pc`, `ret_instr`, `ret_result` in XLEN each: retired PC, instruction word, ALU result.
- `ld_en` in 1: write the expected-trace entry.
- `ld_addr` in log2(DEPTH): entry index.
- `ld_pc`, `ld_instr`, `ld_result` in XLEN each: expected values.
- `ld_mask` in 3: per-entry compare enables {result, instr, pc}; 0 = field ignored.
- `start` in 1: begin checking.
- `len` in log2(DEPTH)+1: number of entries to check; sampled on `start`.
- `stop_on_fail` in 1: sampled on `start`; 1 = finish on first mismatch.
- `busy` out 1: in RUN.
- `done` out 1: in DONE.
- `pass` out 1: done, zero mismatches, no timeout.
- `timeout` out 1: watchdog expired.
- `mismatch_cnt` out CNT_W: saturating mismatch count.
- `first_fail_idx` out log2(DEPTH): index of first mismatch.
- `fail_seen` out 1: at least one mismatch.

## Operation
- States: IDLE, RUN, DONE. On reset, the state goes to IDLE and all outputs go to 0. The trace memory is not reset, and its contents are undefined after power-up.
- IDLE/DONE: `ld_en` writes the entry at `ld_addr`. `ld_en` is ignored in RUN.
- `start` in IDLE or DONE:
  - Clears the counters, flags and `idx`.
  - Latches `len` and `stop_on_fail`. A `len` greater than DEPTH is clamped to DEPTH.
  - Enters RUN. If `len`==0, it goes straight to DONE with `pass`=1.
  - `start` in RUN is ignored.
- RUN, `ret_valid`=1:
  - Compares the retired fields against entry[`idx`], under that entry's mask.
  - On mismatch: `mismatch_cnt`++ (saturates at all-ones). If `fail_seen` is 0, set it and record `first_fail_idx`=`idx`.
  - Then `idx`++.
  - Go to DONE when `idx` reaches `len`-1 on this retire, or when a mismatch occurs with `stop_on_fail`=1.
- RUN, watchdog:
  - The counter clears on entry to RUN and on every `ret_valid`. Otherwise it increments.
  - When it reaches TIMEOUT: set `timeout`=1 and go to DONE.
- `ret_valid` in IDLE/DONE is ignored.
- `pass` = `done` & ~`fail_seen` & ~`timeout`. It is combinational from registers.

## Timing
- Compare latency is 1 cycle. A retire in cycle N updates `mismatch_cnt`, `fail_seen` and `first_fail_idx` at edge N+1.
- `done` is asserted from edge N+1, where N is the final retire. `busy` deasserts at the same edge.
- Timeout: with the last retire (or RUN entry) at edge E, `timeout` and `done` assert at edge E+TIMEOUT.
- If the final retire and the watchdog expiry fall on the same edge, the retire wins: it is compared and `timeout` stays 0.
- Back-to-back retires every cycle are supported with no stall.
- `start` and `ld_en` in the same cycle while in IDLE/DONE: the write completes. The run reads that entry from the next cycle onward.
- Reset asserted mid-RUN clears the state immediately, asynchronously. After release the block is in IDLE and requires a new `start`.
- DONE holds all outputs until the next `start` or reset.

## Test plan
- **Clean match.**
  - Stimulus: load 4 entries (mask 3'b111) matching the PCs 0,4,8,C; `start` with `len`=4; 4 consecutive matching retires.
  - Response: `done` one cycle after the 4th retire; `pass`=1; `mismatch_cnt`=0.
- **Single result mismatch.**
  - Stimulus: corrupt `ret_result` on entry 2 (e.g. 0x5 vs expected 0x7).
  - Response: `mismatch_cnt`=1, `first_fail_idx`=2, `fail_seen`=1, `pass`=0.
- **Mask and stop_on_fail.**
  - Stimulus A: entry 1 has mask 3'b011 and a wrong result. Response: no mismatch.
  - Stimulus B: wrong instruction on entry 1 with `stop_on_fail`=1. Response: DONE at the edge after that retire; `mismatch_cnt`=1; entries 2-3 are not checked.
- **Watchdog.**
  - Stimulus: `TIMEOUT`=8; `len`=3; only 2 retires.
  - Response: `timeout`=1 and `done`=1 exactly 8 edges after the 2nd retire; `pass`=0.
  - Stimulus: the final retire lands on the expiry edge. Response: `timeout`=0.
- **Edge cases.**
  - `len`=0 → `done` and `pass` next edge.
  - `len`=DEPTH+1 → clamped; completes after DEPTH retires.
  - `CNT_W`=2 with 5 mismatches → `mismatch_cnt`=3.
  - Reset pulsed mid-RUN → all outputs 0 and IDLE before the next edge.
  - `start` during RUN → ignored.

Source files
------------

// File: rtl/risc_trace_checker.sv
// Retirement monitor: compares the core's retire stream, in order, against a
// preloaded table of expected (pc, instr, result) triples under per-entry masks.
module risc_trace_checker #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int WD_W   = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ret_valid,
    input  logic [XLEN-1:0] ret_pc,
    input  logic [XLEN-1:0] ret_instr,
    input  logic [XLEN-1:0] ret_result,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_pc,
    input  logic [XLEN-1:0] ld_instr,
    input  logic [XLEN-1:0] ld_result,
    input  logic [2:0]      ld_mask,
    input  logic            start,
    input  logic [AW:0]     len,
    input  logic            stop_on_fail,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [AW-1:0]   first_fail_idx,
    output logic            fail_seen
);

    // state | meaning
    // IDLE  | after reset, table may be loaded, waiting for start
    // RUN   | comparing retires against entry[idx], watchdog armed
    // DONE  | verdict held, table may be reloaded, start re-arms
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] mem_pc     [DEPTH];
    logic [XLEN-1:0] mem_instr  [DEPTH];
    logic [XLEN-1:0] mem_result [DEPTH];
    logic [2:0]      mem_mask   [DEPTH];

    logic [AW-1:0]   idx;
    logic [AW-1:0]   last_q;
    logic            stop_q;
    logic [WD_W-1:0] wd;
    logic [AW:0]     len_clamped;
    logic            hit;
    logic            last;

    always_comb begin
        len_clamped = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
        hit = (~mem_mask[idx][0] | (ret_pc     == mem_pc[idx]))
            & (~mem_mask[idx][1] | (ret_instr  == mem_instr[idx]))
            & (~mem_mask[idx][2] | (ret_result == mem_result[idx]));
        last = (idx == last_q);
    end

    // Table is deliberately unreset; writes are locked out while a run reads it.
    always_ff @(posedge clk) begin
        if (ld_en && state != RUN) begin
            mem_pc[ld_addr]     <= ld_pc;
            mem_instr[ld_addr]  <= ld_instr;
            mem_result[ld_addr] <= ld_result;
            mem_mask[ld_addr]   <= ld_mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            idx            <= '0;
            last_q         <= '0;
            stop_q         <= 1'b0;
            wd             <= '0;
            timeout        <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            fail_seen      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx            <= '0;
                        wd             <= '0;
                        timeout        <= 1'b0;
                        mismatch_cnt   <= '0;
                        first_fail_idx <= '0;
                        fail_seen      <= 1'b0;
                        stop_q         <= stop_on_fail;
                        last_q         <= AW'(len_clamped - (AW+1)'(1));
                        state          <= (len_clamped == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // A retire always beats watchdog expiry on the same edge.
                    if (ret_valid) begin
                        wd  <= '0;
                        idx <= idx + AW'(1);
                        if (!hit) begin
                            if (mismatch_cnt != '1)
                                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                            if (!fail_seen) begin
                                fail_seen      <= 1'b1;
                                first_fail_idx <= idx;
                            end
                        end
                        if (last || (!hit && stop_q))
                            state <= DONE;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        pass = done & ~fail_seen & ~timeout;
    end

endmodule

// File: tb/tb_risc_trace_checker.sv
// Bench for risc_trace_checker: directed scenarios plus randomized runs, all
// checked every cycle against an edge-counting behavioural model.
module tb_risc_trace_checker;
    localparam int XLEN = 32, DEPTH = 8, AW = 3, TIMEOUT = 8, CNT_W = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ret_valid = 1'b0;
    logic [XLEN-1:0] ret_pc = '0, ret_instr = '0, ret_result = '0;
    logic ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [XLEN-1:0] ld_pc = '0, ld_instr = '0, ld_result = '0;
    logic [2:0] ld_mask = '0;
    logic start = 1'b0;
    logic [AW:0] len = '0;
    logic stop_on_fail = 1'b0;
    logic busy, done, pass, timeout, fail_seen;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [AW-1:0] first_fail_idx;

    int n_cmp = 0;
    int n_bad = 0;

    risc_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_instr(ret_instr), .ret_result(ret_result), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_pc(ld_pc), .ld_instr(ld_instr), .ld_result(ld_result), .ld_mask(ld_mask),
        .start(start), .len(len), .stop_on_fail(stop_on_fail), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .mismatch_cnt(mismatch_cnt),
        .first_fail_idx(first_fail_idx), .fail_seen(fail_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected table, list of failing indices, and edge-number bookkeeping.
    logic [XLEN-1:0] t_pc [DEPTH];
    logic [XLEN-1:0] t_instr [DEPTH];
    logic [XLEN-1:0] t_res [DEPTH];
    logic [2:0] t_mask [DEPTH];
    bit m_run, m_done, m_to, m_stop, m_ok;
    int m_len, m_pos, m_edge, m_last, m_e;
    int fails[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run = 0; m_done = 0; m_to = 0; m_stop = 0; m_len = 0; m_pos = 0;
            fails.delete();
        end else begin
            m_edge++;
            if (!m_run) begin
                if (ld_en) begin
                    t_pc[ld_addr] = ld_pc; t_instr[ld_addr] = ld_instr;
                    t_res[ld_addr] = ld_result; t_mask[ld_addr] = ld_mask;
                end
                if (start) begin
                    m_len = (int'(len) > DEPTH) ? DEPTH : int'(len);
                    m_stop = stop_on_fail; m_to = 0; m_pos = 0;
                    fails.delete();
                    if (m_len == 0) m_done = 1;
                    else begin m_run = 1; m_done = 0; m_last = m_edge; end
                end
            end else if (ret_valid) begin
                m_e = m_pos;
                m_ok = (!t_mask[m_e][0] || ret_pc == t_pc[m_e]) &&
                       (!t_mask[m_e][1] || ret_instr == t_instr[m_e]) &&
                       (!t_mask[m_e][2] || ret_result == t_res[m_e]);
                if (!m_ok) fails.push_back(m_pos);
                m_pos++;
                m_last = m_edge;
                if (m_pos == m_len || (!m_ok && m_stop)) begin m_run = 0; m_done = 1; end
            end else if (m_edge - m_last >= TIMEOUT) begin
                m_to = 1; m_run = 0; m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("busy", busy, m_run);
            check("done", done, m_done);
            check("timeout", timeout, m_to);
            check("pass", pass, m_done && fails.size() == 0 && !m_to);
            check("fail_seen", fail_seen, fails.size() != 0);
            check("mismatch_cnt", mismatch_cnt, (fails.size() > 3) ? 3 : fails.size());
            if (fails.size() != 0) check("first_fail_idx", first_fail_idx, fails[0]);
        end
    end

    function automatic logic [XLEN-1:0] f_pc(int i);    return XLEN'(i * 4); endfunction
    function automatic logic [XLEN-1:0] f_instr(int i); return XLEN'(32'h13 | (i << 7)); endfunction
    function automatic logic [XLEN-1:0] f_res(int i);   return XLEN'(i * 3 + 1); endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load(input int a, input logic [XLEN-1:0] p, input logic [XLEN-1:0] ins,
                        input logic [XLEN-1:0] r, input logic [2:0] m);
        ld_en = 1; ld_addr = AW'(a); ld_pc = p; ld_instr = ins; ld_result = r; ld_mask = m;
        tick();
        ld_en = 0;
    endtask

    task automatic do_start(input int l, input bit s);
        start = 1; len = (AW+1)'(l); stop_on_fail = s;
        tick();
        start = 0;
    endtask

    task automatic retire(input logic [XLEN-1:0] p, input logic [XLEN-1:0] ins, input logic [XLEN-1:0] r);
        ret_valid = 1; ret_pc = p; ret_instr = ins; ret_result = r;
        tick();
        ret_valid = 0;
    endtask

    task automatic retire_ok(input int i);
        retire(f_pc(i), f_instr(i), f_res(i));
    endtask

    initial begin
        #8;
        check("rst busy", busy, 0); check("rst done", done, 0); check("rst pass", pass, 0);
        check("rst timeout", timeout, 0); check("rst cnt", mismatch_cnt, 0);
        check("rst ffi", first_fail_idx, 0); check("rst fail_seen", fail_seen, 0);
        #4 reset = 1;
        tick();
        for (int i = 0; i < DEPTH; i++) load(i, f_pc(i), f_instr(i), f_res(i), 3'b111);

        // clean match
        do_start(4, 0);
        for (int i = 0; i < 3; i++) retire_ok(i);
        check("clean done early", done, 0);
        retire_ok(3);
        check("clean done", done, 1); check("clean pass", pass, 1); check("clean cnt", mismatch_cnt, 0);

        // single result mismatch on entry 2
        do_start(4, 0);
        retire_ok(0); retire_ok(1); retire(f_pc(2), f_instr(2), 32'h5); retire_ok(3);
        check("mm cnt", mismatch_cnt, 1); check("mm ffi", first_fail_idx, 2);
        check("mm fail_seen", fail_seen, 1); check("mm pass", pass, 0);

        // masked-off result
        load(1, f_pc(1), f_instr(1), f_res(1), 3'b011);
        do_start(4, 0);
        retire_ok(0); retire(f_pc(1), f_instr(1), 32'hdead); retire_ok(2); retire_ok(3);
        check("mask cnt", mismatch_cnt, 0); check("mask pass", pass, 1);
        load(1, f_pc(1), f_instr(1), f_res(1), 3'b111);

        // stop_on_fail
        do_start(4, 1);
        retire_ok(0); retire(f_pc(1), 32'hbad, f_res(1));
        check("stop done", done, 1); check("stop cnt", mismatch_cnt, 1); check("stop ffi", first_fail_idx, 1);
        retire(32'h1, 32'h1, 32'h1);
        check("stop ignored cnt", mismatch_cnt, 1);

        // watchdog
        do_start(3, 0);
        retire_ok(0); retire_ok(1);
        repeat (TIMEOUT - 1) tick();
        check("wd early", timeout, 0);
        tick();
        check("wd timeout", timeout, 1); check("wd done", done, 1); check("wd pass", pass, 0);

        // final retire on the expiry edge
        do_start(3, 0);
        retire_ok(0); retire_ok(1);
        repeat (TIMEOUT - 1) tick();
        retire_ok(2);
        check("wd race timeout", timeout, 0); check("wd race done", done, 1); check("wd race pass", pass, 1);

        // len = 0
        do_start(0, 0);
        check("len0 done", done, 1); check("len0 pass", pass, 1);

        // len = DEPTH+1 clamps to DEPTH
        do_start(DEPTH + 1, 0);
        for (int i = 0; i < DEPTH - 1; i++) retire_ok(i);
        check("clamp busy", busy, 1);
        retire_ok(DEPTH - 1);
        check("clamp done", done, 1); check("clamp pass", pass, 1);

        // saturating counter
        do_start(DEPTH, 0);
        for (int i = 0; i < DEPTH; i++)
            if (i < 5) retire(f_pc(i) + 1, f_instr(i), f_res(i)); else retire_ok(i);
        check("sat cnt", mismatch_cnt, 3); check("sat ffi", first_fail_idx, 0);

        // start during RUN ignored
        do_start(4, 0);
        retire_ok(0);
        do_start(1, 0);
        check("restart busy", busy, 1);
        retire_ok(1); retire_ok(2); retire_ok(3);
        check("restart done", done, 1); check("restart pass", pass, 1);

        // reset mid-run
        do_start(4, 0);
        retire(32'h77, f_instr(0), f_res(0)); retire_ok(1);
        #2 reset = 0;
        #1;
        check("mid rst busy", busy, 0); check("mid rst cnt", mismatch_cnt, 0);
        check("mid rst fail_seen", fail_seen, 0); check("mid rst done", done, 0);
        reset = 1;
        tick();
        retire_ok(2);
        check("post rst busy", busy, 0);

        // randomized runs
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < DEPTH; i++)
                load(i, $urandom, $urandom, $urandom_range(0, 3) == 0 ? 32'h0 : $urandom,
                     3'($urandom_range(0, 7)));
            ld_en = ($urandom_range(0, 1) == 1); ld_addr = AW'($urandom); ld_pc = $urandom;
            do_start($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            ld_en = 0;
            for (int c = 0; c < 30; c++) begin
                if ($urandom_range(0, 15) == 0) repeat ($urandom_range(5, 10)) tick();
                ret_valid = ($urandom_range(0, 3) != 0);
                ret_pc = t_pc[m_pos % DEPTH]; ret_instr = t_instr[m_pos % DEPTH];
                ret_result = t_res[m_pos % DEPTH];
                case ($urandom_range(0, 9))
                    0: ret_pc = ret_pc ^ 32'h4;
                    1: ret_instr = ret_instr ^ 32'h100;
                    2: ret_result = ret_result + 1;
                    default: ;
                endcase
                ld_en = ($urandom_range(0, 7) == 0); ld_addr = AW'($urandom);
                ld_pc = $urandom; ld_instr = $urandom; ld_result = $urandom;
                ld_mask = 3'($urandom);
                start = ($urandom_range(0, 15) == 0); len = (AW+1)'($urandom);
                tick();
                ret_valid = 0; ld_en = 0; start = 0;
            end
            repeat (TIMEOUT + 1) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
